cacheif_axi4_burst_gen: RTL and testbench
=========================================

Name: cacheIf_axi4_burst_gen

Overview:
- Converts one AXI4-style burst command (addr, len, size, burst, id) into a stream of per-beat cache requests: address, byte-lane strobe, last flag.
- Issues one completion response per command.
- Sits in the copyEngine between the AXI4 slave front-end and the cache interface.
- Uses the package's axsize_t, axburst_t and xresp_t encodings; generalised over address, data and ID widths, with legality checking.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 64, cache data width in bits; power of 2, range 32..1024; B = DATA_W/8 byte lanes
ID_W, 4, transaction ID width
LEN_W, 8, burst length field width (beats-1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when both high
cmd_id  in  ID_W  transaction ID
cmd_addr  in  ADDR_W  start byte address
cmd_len  in  LEN_W  beats-1
cmd_size  in  3  bytes per beat, axsize_t encoding
cmd_burst  in  2  axburst_t encoding
beat_valid  out  1  beat request valid
beat_ready  in  1  cache accepts beat
beat_addr  out  ADDR_W  beat byte address
beat_strb  out  B  active byte lanes
beat_last  out  1  final beat of burst
beat_id  out  ID_W  ID of current burst
resp_valid  out  1  completion valid
resp_ready  in  1  completion accepted
resp_id  out  ID_W  completion ID
resp_code  out  2  xresp_t encoding

Behaviour:
- Reset (async, rstn=0): state IDLE; all beat_*/resp_* outputs 0; cmd_ready=1 (IDLE) after rstn releases. Any in-flight burst is discarded and produces no response.
- FSM states: IDLE, BURST, RESP.
- cmd_ready = (state==IDLE). Only one command is outstanding at a time.
- IDLE: on cmd handshake, latch all fields and legality-check them in the same cycle.
  - Legal -> BURST; beat 0 valid the next cycle.
  - Illegal -> RESP with SLVERR; no beats issued.
- Illegal conditions (SZ = 1<<cmd_size):
  - SZ > B.
  - cmd_burst = Rsvd.
  - WRAP with cmd_len not in {1,3,7,15}.
  - WRAP with cmd_addr not SZ-aligned.
  - INCR whose last byte lies in a different 4KB page than cmd_addr.
- Address per beat n (beat 0 = cmd_addr):
  - FIXED: cmd_addr for every beat.
  - INCR: A(n) = align(cmd_addr, SZ) + n*SZ for n>=1.
  - WRAP: W = (len+1)*SZ; lower = cmd_addr & ~(W-1); next = cur+SZ, and if next == lower+W then next = lower.
- Strobe: lanes [align(addr,SZ) mod B .. +SZ-1], with lanes below (addr mod B) cleared. This clears lanes only for an unaligned beat (beat 0 of INCR, every beat of FIXED).
- BURST:
  - Outputs are registered and held stable while beat_valid && !beat_ready.
  - Each handshake advances one beat; throughput is one beat per cycle with beat_ready held high.
  - beat_last = (beat counter == latched len).
  - Handshake on the last beat -> RESP with OKAY; beat_valid drops the next cycle.
- RESP: resp_valid=1, resp_id = latched ID, resp_code held until resp_ready. On handshake -> IDLE, so cmd_ready=1 the next cycle.
- Latency: cmd handshake to beat 0 valid = 1 cycle; last-beat handshake to resp_valid = 1 cycle.
- Beat counter is LEN_W+1 bits wide, so len = 2^LEN_W-1 completes without wrap; address arithmetic is modulo 2^ADDR_W.

Test Plan:
All cases use DATA_W=64 (B=8).
1. INCR addr 0x1004, len 3, size 4B, beat_ready=1 -> addrs 0x1004/0x1008/0x100C/0x1010; strb 0xF0/0x0F/0xF0/0x0F; last on beat 3; resp OKAY 1 cycle later; cmd_ready back after resp handshake.
2. INCR addr 0x1002, len 1, size 4B -> beat0 addr 0x1002 strb 0x0C; beat1 addr 0x1004 strb 0xF0; OKAY.
3. WRAP addr 0x38, len 3, size 8B -> addrs 0x38/0x20/0x28/0x30, all strb 0xFF; then WRAP addr 0x34, len 3, size 8B -> no beats, SLVERR.
4. FIXED addr 0x100, len 2, size 2B -> three beats at 0x100, strb 0x03, last on beat 2.
5. Illegal commands -> no beat_valid, resp SLVERR with matching resp_id, for each of:
   - size 16B;
   - burst=3;
   - WRAP len 2;
   - INCR addr 0xFFC, len 1, size 4B (crosses 4KB page).
6. Backpressure and reset:
   - beat_ready low 3 cycles on beat 1 -> addr/strb/last stable;
   - resp_ready low 2 cycles -> resp held, cmd_ready=0;
   - rstn pulsed low mid-burst -> outputs 0 immediately, no resp; next command runs cleanly from beat 0.

Source files
------------

// File: rtl/cacheif_axi4_burst_gen.sv
// AXI4 burst command to per-beat cache request generator with legality checking.
// One command outstanding at a time; one completion response per command.
module cacheif_axi4_burst_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_W-1:0]     beat_addr,
  output logic [DATA_W/8-1:0]   beat_strb,
  output logic                  beat_last,
  output logic [ID_W-1:0]       beat_id,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [1:0]            resp_code
);

  localparam int unsigned B      = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(B);
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned SPAN_W = LEN_W + 22;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_RESP} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] lower_q, lower_d;
  logic [ADDR_W-1:0] bound_q, bound_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              cmd_ready_d;
  logic              beat_valid_d, beat_last_d;
  logic [ADDR_W-1:0] beat_addr_d;
  logic [B-1:0]      beat_strb_d;
  logic [ID_W-1:0]   beat_id_d, resp_id_d;
  logic              resp_valid_d;
  logic [1:0]        resp_code_d;

  // Low-order byte mask of a beat of 2^sz bytes.
  function automatic logic [ADDR_W-1:0] size_mask(input logic [2:0] sz);
    return ADDR_W'((64'd1 << sz) - 64'd1);
  endfunction

  // Lanes from the aligned beat start up to its end, minus lanes below the byte address.
  function automatic logic [B-1:0] lane_strb(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
    logic [ADDR_W-1:0] m;
    logic [LANE_W:0]   lo, hi;
    logic [B-1:0]      s;
    m  = size_mask(sz);
    lo = {1'b0, a[LANE_W-1:0]};
    hi = {1'b0, a[LANE_W-1:0] & ~m[LANE_W-1:0]} + ((LANE_W+1)'(1) << sz);
    for (int unsigned i = 0; i < B; i++) begin
      s[i] = ((LANE_W+1)'(i) >= lo) && ((LANE_W+1)'(i) < hi);
    end
    return s;
  endfunction

  // Command legality and wrap window, evaluated on the incoming fields.
  logic [ADDR_W-1:0] cmd_mask, wrap_w, wrap_lower;
  logic [SPAN_W-1:0] span;
  logic              wrap_len_ok, cmd_legal;

  always_comb begin
    cmd_mask    = size_mask(cmd_size);
    wrap_w      = ADDR_W'({1'b0, cmd_len} + CNT_W'(1)) << cmd_size;
    wrap_lower  = cmd_addr & ~(wrap_w - ADDR_W'(1));
    span        = SPAN_W'(cmd_addr[11:0] & ~cmd_mask[11:0])
                + (SPAN_W'({1'b0, cmd_len} + CNT_W'(1)) << cmd_size) - SPAN_W'(1);
    wrap_len_ok = (cmd_len == LEN_W'(1)) || (cmd_len == LEN_W'(3)) ||
                  (cmd_len == LEN_W'(7)) || (cmd_len == LEN_W'(15));
    cmd_legal   = 1'b1;
    if (cmd_size > 3'(LANE_W))                                         cmd_legal = 1'b0;
    if (cmd_burst == BURST_RSVD)                                       cmd_legal = 1'b0;
    if ((cmd_burst == BURST_WRAP) && !wrap_len_ok)                     cmd_legal = 1'b0;
    if ((cmd_burst == BURST_WRAP) && ((cmd_addr & cmd_mask) != '0))    cmd_legal = 1'b0;
    if ((cmd_burst == BURST_INCR) && (span[SPAN_W-1:12] != '0))        cmd_legal = 1'b0;
  end

  // Address of the beat following the one currently presented.
  logic [ADDR_W-1:0] beat_mask, step, wrap_nxt, addr_nxt;
  logic [CNT_W-1:0]  cnt_inc;

  always_comb begin
    beat_mask = size_mask(size_q);
    step      = beat_mask + ADDR_W'(1);
    wrap_nxt  = beat_addr + step;
    cnt_inc   = cnt_q + CNT_W'(1);
    case (burst_q)
      BURST_INCR: addr_nxt = (beat_addr & ~beat_mask) + step;
      BURST_WRAP: addr_nxt = (wrap_nxt == bound_q) ? lower_q : wrap_nxt;
      default:    addr_nxt = beat_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid && cmd_ready) state_d = cmd_legal ? ST_BURST : ST_RESP;
      ST_BURST: if (beat_ready && beat_last) state_d = ST_RESP;
      ST_RESP:  if (resp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_d         = id_q;
    len_d        = len_q;
    size_d       = size_q;
    burst_d      = burst_q;
    lower_d      = lower_q;
    bound_d      = bound_q;
    cnt_d        = cnt_q;
    beat_valid_d = beat_valid;
    beat_addr_d  = beat_addr;
    beat_strb_d  = beat_strb;
    beat_last_d  = beat_last;
    beat_id_d    = beat_id;
    resp_valid_d = resp_valid;
    resp_id_d    = resp_id;
    resp_code_d  = resp_code;
    cmd_ready_d  = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          id_d    = cmd_id;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          lower_d = wrap_lower;
          bound_d = wrap_lower + wrap_w;
          cnt_d   = '0;
          if (cmd_legal) begin
            beat_valid_d = 1'b1;
            beat_addr_d  = cmd_addr;
            beat_strb_d  = lane_strb(cmd_addr, cmd_size);
            beat_last_d  = (cmd_len == '0);
            beat_id_d    = cmd_id;
          end else begin
            resp_valid_d = 1'b1;
            resp_id_d    = cmd_id;
            resp_code_d  = RESP_SLVERR;
          end
        end
      end
      ST_BURST: begin
        if (beat_ready) begin
          if (beat_last) begin
            beat_valid_d = 1'b0;
            beat_last_d  = 1'b0;
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            resp_code_d  = RESP_OKAY;
          end else begin
            cnt_d       = cnt_inc;
            beat_addr_d = addr_nxt;
            beat_strb_d = lane_strb(addr_nxt, size_q);
            beat_last_d = (cnt_inc == {1'b0, len_q});
          end
        end
      end
      ST_RESP: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q       <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= BURST_FIXED;
      lower_q    <= '0;
      bound_q    <= '0;
      cnt_q      <= '0;
      cmd_ready  <= 1'b1;
      beat_valid <= 1'b0;
      beat_addr  <= '0;
      beat_strb  <= '0;
      beat_last  <= 1'b0;
      beat_id    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_code  <= RESP_OKAY;
    end else begin
      id_q       <= id_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      lower_q    <= lower_d;
      bound_q    <= bound_d;
      cnt_q      <= cnt_d;
      cmd_ready  <= cmd_ready_d;
      beat_valid <= beat_valid_d;
      beat_addr  <= beat_addr_d;
      beat_strb  <= beat_strb_d;
      beat_last  <= beat_last_d;
      beat_id    <= beat_id_d;
      resp_valid <= resp_valid_d;
      resp_id    <= resp_id_d;
      resp_code  <= resp_code_d;
    end
  end

endmodule

// File: tb/tb_cacheif_axi4_burst_gen.sv
// Scoreboard bench for cacheif_axi4_burst_gen: directed cases plus randomized commands
// checked against a per-command beat list computed from the AXI4 burst rules.
module tb_cacheif_axi4_burst_gen;

  logic        clk, rstn;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid, beat_ready, beat_last;
  logic [31:0] beat_addr;
  logic [7:0]  beat_strb;
  logic [3:0]  beat_id;
  logic        resp_valid, resp_ready;
  logic [3:0]  resp_id;
  logic [1:0]  resp_code;

  cacheif_axi4_burst_gen dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
    .beat_strb(beat_strb), .beat_last(beat_last), .beat_id(beat_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_code(resp_code)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  strb;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] code;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rnd_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected beats and response for one command, straight from the burst rules.
  function automatic void model(input logic [3:0] id, input logic [31:0] addr, input int len,
                                input int size, input int burst);
    longint a0, sz, w, lower, a, al, lo, st, lastb;
    bit     bad;
    beat_t  b;
    resp_t  r;
    a0  = longint'(addr);
    sz  = longint'(1) << size;
    bad = (sz > 8) || (burst == 3);
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) bad = 1;
    if (burst == 2 && (a0 % sz) != 0) bad = 1;
    if (burst == 1 && sz <= 8) begin
      lastb = (a0 - a0 % sz) + longint'(len + 1) * sz - 1;
      if ((lastb >> 12) != (a0 >> 12)) bad = 1;
    end
    r.id = id;
    if (bad) begin
      r.code = 2'd2;
      resp_q.push_back(r);
      return;
    end
    w     = longint'(len + 1) * sz;
    lower = a0 - a0 % w;
    for (int n = 0; n <= len; n++) begin
      if (burst == 0)      a = a0;
      else if (burst == 1) a = (n == 0) ? a0 : ((a0 - a0 % sz + longint'(n) * sz) & 64'hFFFF_FFFF);
      else                 a = lower + ((a0 - lower) + longint'(n) * sz) % w;
      al = a - a % sz;
      lo = a % 8;
      st = al % 8;
      for (int j = 0; j < 8; j++) b.strb[j] = (j >= lo) && (j < st + sz);
      b.addr = a[31:0];
      b.last = (n == len);
      b.id   = id;
      beat_q.push_back(b);
    end
    r.code = 2'd0;
    resp_q.push_back(r);
  endfunction

  // Monitor: pops the scoreboard on every beat/response handshake.
  beat_t held;
  bit    hold = 0;
  always @(negedge clk) begin
    beat_t e;
    resp_t er;
    if (!rstn) begin
      hold = 0;
    end else begin
      if (hold && beat_valid) begin
        check("stall_addr_stable", 64'(beat_addr), 64'(held.addr));
        check("stall_strb_stable", 64'(beat_strb), 64'(held.strb));
        check("stall_last_stable", 64'(beat_last), 64'(held.last));
      end
      hold = beat_valid && !beat_ready;
      held = '{addr: beat_addr, strb: beat_strb, last: beat_last, id: beat_id};
      if (beat_valid && beat_ready) begin
        if (beat_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", beat_addr);
        end else begin
          e = beat_q.pop_front();
          check("beat_addr", 64'(beat_addr), 64'(e.addr));
          check("beat_strb", 64'(beat_strb), 64'(e.strb));
          check("beat_last", 64'(beat_last), 64'(e.last));
          check("beat_id",   64'(beat_id),   64'(e.id));
        end
      end
      if (resp_valid && resp_ready) begin
        check("resp_after_all_beats", 64'(beat_q.size()), 64'd0);
        if (resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_resp: got id 0x%0h expected no response", resp_id);
        end else begin
          er = resp_q.pop_front();
          check("resp_id",   64'(resp_id),   64'(er.id));
          check("resp_code", 64'(resp_code), 64'(er.code));
        end
      end
    end
  end

  // Random backpressure while rnd_on is set.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_on) begin
      beat_ready = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 3000) begin
      tick();
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout: got cmd_ready 0 expected 1 within 3000 cycles");
      cmd_valid = 1'b0;
      return;
    end
    model(id, addr, int'(len), int'(size), int'(burst));
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(beat_q.size() == 0 && resp_q.size() == 0 && cmd_ready) && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d beats %0d resps pending expected 0", beat_q.size(), resp_q.size());
    end
  endtask

  initial begin
    logic [31:0] a, m;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  bt;
    int          r;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; beat_ready = 1'b1; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("reset_cmd_ready",  64'(cmd_ready),  64'd1);
    check("reset_beat_valid", 64'(beat_valid), 64'd0);
    check("reset_beat_addr",  64'(beat_addr),  64'd0);
    check("reset_beat_strb",  64'(beat_strb),  64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_code",  64'(resp_code),  64'd0);

    // INCR unaligned start with latency checks
    send_cmd(4'd1, 32'h1004, 8'd3, 3'd2, 2'd1);
    check("t1_beat0_latency", 64'(beat_valid), 64'd1);
    repeat (3) tick();
    check("t1_last_on_beat3", 64'(beat_last), 64'd1);
    check("t1_no_early_resp", 64'(resp_valid), 64'd0);
    tick();
    check("t1_beat_valid_drop", 64'(beat_valid), 64'd0);
    check("t1_resp_latency",    64'(resp_valid), 64'd1);
    check("t1_cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
    tick();
    check("t1_resp_done",       64'(resp_valid), 64'd0);
    check("t1_cmd_ready_back",  64'(cmd_ready),  64'd1);

    send_cmd(4'd2, 32'h1002, 8'd1, 3'd2, 2'd1);
    drain();
    send_cmd(4'd3, 32'h38, 8'd3, 3'd3, 2'd2);
    drain();
    send_cmd(4'd4, 32'h34, 8'd3, 3'd3, 2'd2);
    drain();
    send_cmd(4'd5, 32'h100, 8'd2, 3'd1, 2'd0);
    drain();

    // Illegal commands: no beats, SLVERR one cycle after acceptance
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: send_cmd(4'd6, 32'h0,   8'd0, 3'd4, 2'd1);
        1: send_cmd(4'd7, 32'h40,  8'd1, 3'd2, 2'd3);
        2: send_cmd(4'd8, 32'h0,   8'd2, 3'd2, 2'd2);
        default: send_cmd(4'd9, 32'hFFC, 8'd1, 3'd2, 2'd1);
      endcase
      check("t5_no_beat",      64'(beat_valid), 64'd0);
      check("t5_resp_latency", 64'(resp_valid), 64'd1);
      drain();
    end

    // Maximum length and address-space wrap of a WRAP burst
    send_cmd(4'd10, 32'h2000, 8'd255, 3'd0, 2'd1);
    drain();
    send_cmd(4'd11, 32'hFFFF_FFF8, 8'd1, 3'd2, 2'd2);
    drain();

    // Beat backpressure on beat 1
    send_cmd(4'd12, 32'h3000, 8'd3, 3'd3, 2'd1);
    tick();
    beat_ready = 1'b0;
    repeat (3) tick();
    check("t6_stalled_beat1_addr", 64'(beat_addr), 64'h3008);
    beat_ready = 1'b1;
    drain();

    // Response backpressure
    resp_ready = 1'b0;
    send_cmd(4'd13, 32'h4000, 8'd1, 3'd2, 2'd1);
    r = 0;
    while (!resp_valid && r < 50) begin tick(); r++; end
    for (int k = 0; k < 3; k++) begin
      check("t6_resp_held",      64'(resp_valid), 64'd1);
      check("t6_resp_id_held",   64'(resp_id),    64'd13);
      check("t6_cmd_ready_low",  64'(cmd_ready),  64'd0);
      if (k < 2) tick();
    end
    resp_ready = 1'b1;
    drain();

    // Reset mid-burst discards the burst
    send_cmd(4'd14, 32'h5000, 8'd7, 3'd2, 2'd1);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("t6_rst_beat_valid", 64'(beat_valid), 64'd0);
    check("t6_rst_beat_addr",  64'(beat_addr),  64'd0);
    check("t6_rst_beat_last",  64'(beat_last),  64'd0);
    check("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
    beat_q.delete();
    resp_q.delete();
    tick();
    rstn = 1'b1;
    repeat (4) tick();
    check("t6_rst_no_resp",   64'(resp_valid), 64'd0);
    check("t6_rst_cmd_ready", 64'(cmd_ready),  64'd1);
    send_cmd(4'd15, 32'h6004, 8'd2, 3'd2, 2'd1);
    drain();

    // Randomized commands with random backpressure
    rnd_on = 1;
    for (int k = 0; k < 200; k++) begin
      s  = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      bt = (r < 2) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if (bt == 2'd2 && $urandom_range(0, 5) != 0) begin
        r = $urandom_range(0, 3);
        l = 8'((2 << r) - 1);
      end else if ($urandom_range(0, 19) == 0) begin
        l = 8'($urandom_range(0, 255));
      end else begin
        l = 8'($urandom_range(0, 15));
      end
      a = $urandom;
      m = (32'd1 << s) - 32'd1;
      if ($urandom_range(0, 1) != 0) a = a & ~m;
      if ($urandom_range(0, 2) == 0) a[11:6] = 6'h3F;
      send_cmd(4'($urandom_range(0, 15)), a, l, s, bt);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rnd_on = 0;
    beat_ready = 1'b1;
    resp_ready = 1'b1;
    check("final_scoreboard_empty", 64'(beat_q.size() + resp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
